// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the I/D cache miss controller: state encoding and
// line-geometry helpers.
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    GAP        = 2'd2,
    FILL       = 2'd3
  } state_t;

  function automatic int off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int line_w(input int word_w, input int words_per_line);
    return word_w * words_per_line;
  endfunction

endpackage

// File: rtl/cache_word_merge.sv
// Replaces one word of a cache line with store data, selected by word offset.
module cache_word_merge #(
  parameter int WORD_W = 16,
  parameter int WORDS  = 4,
  parameter int OFF_W  = 2
) (
  input  logic [WORD_W*WORDS-1:0] line,
  input  logic [WORD_W-1:0]       word,
  input  logic [OFF_W-1:0]        offset,
  output logic [WORD_W*WORDS-1:0] merged
);

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    assign merged[gi*WORD_W +: WORD_W] =
      (offset == OFF_W'(gi)) ? word : line[gi*WORD_W +: WORD_W];
  end

endmodule

// File: rtl/cache_ctrl_param.sv
// Split I/D cache miss controller over one line-wide memory port, one miss at a time.
// Define CACHE_CTRL_STATS_EN to add saturating miss/write-back counters.
module cache_ctrl_param
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int WORD_W         = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_W          = 8,
  parameter int STREAK_MAX     = 3,
  localparam int OFF_W  = off_w(WORDS_PER_LINE),
  localparam int LINE_W = line_w(WORD_W, WORDS_PER_LINE),
  localparam int LA_W   = ADDR_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_acc,
  input  logic              d_acc,
  input  logic              read,
  input  logic              write,
  input  logic              i_hit,
  input  logic              d_hit,
  input  logic              dirty,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [TAG_W-1:0]  d_tag,
  input  logic [LINE_W-1:0] d_line,
  input  logic [LINE_W-1:0] m_line,
  input  logic              mem_rdy,
  output logic              i_we,
  output logic              d_we,
  output logic              d_dirt_in,
  output logic              m_re,
  output logic              m_we,
  output logic              rdy,
  output logic              busy,
  output logic [LINE_W-1:0] i_data,
  output logic [LINE_W-1:0] d_data,
  output logic [LINE_W-1:0] m_data,
  output logic [LA_W-1:0]   m_addr
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0]       i_miss_cnt,
  output logic [15:0]       d_miss_cnt,
  output logic [15:0]       wb_cnt
`endif
);

  localparam int IDX_W = LA_W - TAG_W;
  localparam int SW    = $clog2(STREAK_MAX + 1);

  state_t          state;
  logic            svc_d;
  logic [SW-1:0]   d_streak;
  logic [LA_W-1:0] fill_addr_reg;
  logic [LA_W-1:0] wb_addr_reg;

  logic dmiss, imiss, pick_i, pick_d;
  logic [LA_W-1:0]   i_line_addr, d_line_addr, wb_line_addr;
  logic [LINE_W-1:0] hit_merged, fill_merged;
  logic              unused_bits;

  assign dmiss        = d_acc & ~d_hit;
  assign imiss        = i_acc & ~i_hit;
  assign pick_i       = imiss & (~dmiss | (d_streak == SW'(STREAK_MAX)));
  assign pick_d       = dmiss & ~pick_i;
  assign i_line_addr  = i_addr[ADDR_W-1:OFF_W];
  assign d_line_addr  = d_addr[ADDR_W-1:OFF_W];
  assign wb_line_addr = {d_tag, d_addr[OFF_W+IDX_W-1:OFF_W]};
  assign unused_bits  = ^{read, i_addr[OFF_W-1:0]};

  cache_word_merge #(.WORD_W(WORD_W), .WORDS(WORDS_PER_LINE), .OFF_W(OFF_W)) u_hit_merge (
    .line(d_line), .word(wr_data), .offset(d_addr[OFF_W-1:0]), .merged(hit_merged)
  );

  cache_word_merge #(.WORD_W(WORD_W), .WORDS(WORDS_PER_LINE), .OFF_W(OFF_W)) u_fill_merge (
    .line(m_line), .word(wr_data), .offset(d_addr[OFF_W-1:0]), .merged(fill_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      svc_d         <= 1'b0;
      d_streak      <= '0;
      fill_addr_reg <= '0;
      wb_addr_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          wb_addr_reg <= wb_line_addr;
          if (pick_i) begin
            svc_d         <= 1'b0;
            d_streak      <= '0;
            fill_addr_reg <= i_line_addr;
            state         <= FILL;
          end else if (pick_d) begin
            svc_d         <= 1'b1;
            fill_addr_reg <= d_line_addr;
            if (d_streak != SW'(STREAK_MAX)) d_streak <= d_streak + 1'b1;
            state <= dirty ? WRITE_BACK : FILL;
          end else if (!imiss) begin
            d_streak <= '0;
          end
        end
        WRITE_BACK: if (mem_rdy) state <= GAP;
        // GAP never looks at mem_rdy, so the write-back completion cannot end the fill.
        GAP:        state <= FILL;
        FILL:       if (mem_rdy) state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  always_comb begin
    i_we      = 1'b0;
    d_we      = 1'b0;
    d_dirt_in = 1'b0;
    m_re      = 1'b0;
    m_we      = 1'b0;
    rdy       = 1'b0;
    busy      = 1'b0;
    i_data    = '0;
    d_data    = '0;
    m_data    = d_line;
    m_addr    = '0;
    if (!rst) begin
      busy = (state != IDLE);
      case (state)
        IDLE: begin
          if (pick_i) begin
            m_re   = 1'b1;
            m_addr = i_line_addr;
          end else if (pick_d) begin
            m_we   = dirty;
            m_re   = ~dirty;
            m_addr = dirty ? wb_line_addr : d_line_addr;
          end else begin
            rdy = 1'b1;
            if (write && d_acc) begin
              d_we      = 1'b1;
              d_dirt_in = 1'b1;
              d_data    = hit_merged;
            end
          end
        end
        WRITE_BACK: begin
          m_we   = 1'b1;
          m_addr = wb_addr_reg;
        end
        GAP: begin
          m_re   = 1'b1;
          m_addr = fill_addr_reg;
        end
        FILL: begin
          m_re   = 1'b1;
          m_addr = fill_addr_reg;
          // The side written is the one latched at pick time, not the live hit lines.
          if (mem_rdy) begin
            if (svc_d) begin
              d_we      = 1'b1;
              d_data    = write ? fill_merged : m_line;
              d_dirt_in = write;
            end else begin
              i_we   = 1'b1;
              i_data = m_line;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_miss_cnt <= '0;
      d_miss_cnt <= '0;
      wb_cnt     <= '0;
    end else if (state == IDLE) begin
      if (pick_i && i_miss_cnt != 16'hFFFF) i_miss_cnt <= i_miss_cnt + 16'd1;
      if (pick_d && d_miss_cnt != 16'hFFFF) d_miss_cnt <= d_miss_cnt + 16'd1;
      if (pick_d && dirty && wb_cnt != 16'hFFFF) wb_cnt <= wb_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl_param.sv
// Directed bench for cache_ctrl_param: reset, clean/dirty misses, write hit,
// anti-starvation order and fill-side selection.
module tb_cache_ctrl_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_acc, d_acc, read, write, i_hit, d_hit, dirty, mem_rdy;
  logic [15:0] i_addr, d_addr, wr_data;
  logic [7:0]  d_tag;
  logic [63:0] d_line, m_line;
  logic        i_we, d_we, d_dirt_in, m_re, m_we, rdy, busy;
  logic [63:0] i_data, d_data, m_data;
  logic [13:0] m_addr;
`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] i_miss_cnt, d_miss_cnt, wb_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_ctrl_param dut (
    .clk(clk), .rst(rst), .i_acc(i_acc), .d_acc(d_acc), .read(read), .write(write),
    .i_hit(i_hit), .d_hit(d_hit), .dirty(dirty), .i_addr(i_addr), .d_addr(d_addr),
    .wr_data(wr_data), .d_tag(d_tag), .d_line(d_line), .m_line(m_line), .mem_rdy(mem_rdy),
    .i_we(i_we), .d_we(d_we), .d_dirt_in(d_dirt_in), .m_re(m_re), .m_we(m_we), .rdy(rdy),
    .busy(busy), .i_data(i_data), .d_data(d_data), .m_data(m_data), .m_addr(m_addr)
`ifdef CACHE_CTRL_STATS_EN
    , .i_miss_cnt(i_miss_cnt), .d_miss_cnt(d_miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    i_acc = 0; d_acc = 0; read = 0; write = 0; i_hit = 1; d_hit = 1; dirty = 0;
    mem_rdy = 0; i_addr = 16'h0; d_addr = 16'h0; wr_data = 16'h0; d_tag = 8'h0;
    d_line = 64'h0; m_line = 64'h0;
  endtask

  initial begin
    string exp_order;
    string got_order;
    quiet();
    rst = 1;
    d_line = 64'hCAFE_F00D_1234_5678;
    #2;
    check("rst_rdy", 64'(rdy), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mdata", m_data, 64'hCAFE_F00D_1234_5678);
    tick();
    rst = 0;
    #1;
    check("idle_rdy", 64'(rdy), 64'd1);
    $display("txn reset");

    // Clean D read miss
    quiet(); d_acc = 1; read = 1; d_hit = 0; d_addr = 16'h1234; m_line = 64'h0102_0304_0506_0708;
    #1;
    check("clean_mre", 64'(m_re), 64'd1);
    check("clean_maddr", 64'(m_addr), 64'h048D);
    tick();
    check("clean_busy", 64'(busy), 64'd1);
    check("clean_fill_rdy", 64'(rdy), 64'd0);
    tick(); tick();
    mem_rdy = 1; #1;
    check("clean_dwe", 64'(d_we), 64'd1);
    check("clean_ddata", d_data, 64'h0102_0304_0506_0708);
    check("clean_dirt", 64'(d_dirt_in), 64'd0);
    tick();
    mem_rdy = 0; d_hit = 1; #1;
    check("clean_rdy_after", 64'(rdy), 64'd1);
    $display("txn clean D read miss addr 1234");

    // Dirty D write miss
    quiet(); d_acc = 1; write = 1; d_hit = 0; dirty = 1; d_tag = 8'hAB;
    d_addr = 16'h1236; wr_data = 16'hBEEF; d_line = 64'hDEAD_DEAD_DEAD_DEAD;
    #1;
    check("dirty_mwe", 64'(m_we), 64'd1);
    check("dirty_maddr_idle", 64'(m_addr), 64'h2ACD);
    tick();
    check("wb_mwe", 64'(m_we), 64'd1);
    check("wb_maddr", 64'(m_addr), 64'h2ACD);
    check("wb_mdata", m_data, 64'hDEAD_DEAD_DEAD_DEAD);
    mem_rdy = 1;
    tick();
    #1;
    check("gap_mre", 64'(m_re), 64'd1);
    check("gap_maddr", 64'(m_addr), 64'h048D);
    check("gap_no_dwe", 64'(d_we), 64'd0);
    tick();
    mem_rdy = 0; #1;
    check("dfill_busy", 64'(busy), 64'd1);
    check("dfill_wait_dwe", 64'(d_we), 64'd0);
    tick();
    mem_rdy = 1; m_line = 64'h1111_2222_3333_4444; #1;
    check("dirty_dwe", 64'(d_we), 64'd1);
    check("dirty_ddata", d_data, 64'h1111_BEEF_3333_4444);
    check("dirty_dirt", 64'(d_dirt_in), 64'd1);
    tick();
    quiet(); #1;
    $display("txn dirty D write miss addr 1236 tag AB");

    // Write hit at offset 3
    d_acc = 1; write = 1; d_addr = 16'h0003; wr_data = 16'h5A5A; #1;
    check("hit_rdy", 64'(rdy), 64'd1);
    check("hit_dwe", 64'(d_we), 64'd1);
    check("hit_ddata", d_data, 64'h5A5A_0000_0000_0000);
    check("hit_dirt", 64'(d_dirt_in), 64'd1);
    tick();
    $display("txn write hit offset 3");

    // Continuous D and I misses: anti-starvation order
    quiet(); d_acc = 1; read = 1; d_hit = 0; d_addr = 16'h1234;
    i_acc = 1; i_hit = 0; i_addr = 16'h0100; m_line = 64'h7777_6666_5555_4444;
    #1;
    exp_order = "DDDIDDDI";
    got_order = "";
    for (int k = 0; k < 8; k++) begin
      logic side_i;
      side_i = (m_addr == 14'h0040);
      got_order = {got_order, side_i ? "I" : "D"};
      tick();
      mem_rdy = 1; #1;
      check("order_we", {62'd0, i_we, d_we}, side_i ? 64'd2 : 64'd1);
      tick();
      mem_rdy = 0; #1;
    end
    checks++;
    if (got_order != exp_order) begin
      errors++;
      $display("FAIL order got %s expected %s", got_order, exp_order);
    end
    $display("txn streak order %s", got_order);

    // Live hit/acc changes during FILL must not redirect the write
    quiet(); d_acc = 1; read = 1; d_hit = 0; d_addr = 16'h1234; m_line = 64'hAAAA_BBBB_CCCC_DDDD;
    #1; tick();
    d_hit = 1; d_acc = 0; i_acc = 1; i_hit = 0; mem_rdy = 1; #1;
    check("svc_d_dwe", 64'(d_we), 64'd1);
    check("svc_d_iwe", 64'(i_we), 64'd0);
    check("svc_d_maddr", 64'(m_addr), 64'h048D);
    tick();
    quiet(); i_acc = 1; i_hit = 0; i_addr = 16'h0100; m_line = 64'h0F0F_0F0F_0F0F_0F0F;
    #1; tick();
    i_acc = 0; d_acc = 1; d_hit = 0; mem_rdy = 1; #1;
    check("svc_i_iwe", 64'(i_we), 64'd1);
    check("svc_i_idata", i_data, 64'h0F0F_0F0F_0F0F_0F0F);
    check("svc_i_dwe", 64'(d_we), 64'd0);
    tick();
    quiet(); #1;
    $display("txn fill side follows latched service");

    // Reset in the middle of a fill
    d_acc = 1; read = 1; d_hit = 0; d_addr = 16'h1234; #1;
    tick();
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1; #1;
    check("rst_fill_busy", 64'(busy), 64'd0);
    check("rst_fill_mre", 64'(m_re), 64'd0);
    mem_rdy = 1; #1;
    check("rst_fill_dwe", 64'(d_we), 64'd0);
    check("rst_fill_iwe", 64'(i_we), 64'd0);
    tick();
    d_acc = 0; d_hit = 1; rst = 0; #1;
    check("post_rst_rdy", 64'(rdy), 64'd1);
    check("post_rst_dwe", 64'(d_we), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    $display("txn reset mid fill");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
